// File: rtl/traffic_phase_seq.sv
// Traffic-light phase sequencer for N_APPR approaches.
// Self-timed green/flash/yellow/all-red cycle; mode commands via valid/ready.
module traffic_phase_seq #(
  parameter int N_APPR   = 4,
  parameter int TICK_DIV = 13_500_000,
  parameter int GREEN_T  = 40,
  parameter int GFLASH_T = 6,
  parameter int YELLOW_T = 6,
  parameter int ALLRED_T = 2,
  parameter int TW       = 8,
  localparam int AW      = $clog2(N_APPR),
  localparam int LW      = 3 * N_APPR,
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_mode,
  input  logic [AW-1:0] cmd_appr,
  output logic          cmd_ready,
  output logic [LW-1:0] lights,
  output logic [AW-1:0] cur_appr,
  output logic [2:0]    state_o
);

  localparam logic [2:0] ST_ALLRED = 3'd0;
  localparam logic [2:0] ST_GREEN  = 3'd1;
  localparam logic [2:0] ST_GFLASH = 3'd2;
  localparam logic [2:0] ST_YELLOW = 3'd3;
  localparam logic [2:0] ST_FLASH  = 3'd4;

  localparam logic [1:0] M_AUTO   = 2'd0;
  localparam logic [1:0] M_MANUAL = 2'd1;
  localparam logic [1:0] M_FLASH  = 2'd2;
  localparam logic [1:0] M_ALLRED = 2'd3;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          blink_q, blink_d;
  logic [2:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [LW-1:0] lights_q, lights_d;

  logic tick;
  logic accept;
  logic bad_appr;
  logic hold;

  assign tick    = presc_q == PW'(TICK_DIV - 1);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign blink_d = blink_q ^ tick;

  assign cmd_ready = !(state_q == ST_GFLASH || state_q == ST_YELLOW);
  assign accept    = cmd_valid && cmd_ready;
  assign bad_appr  = cmd_mode == M_MANUAL &&
                     {1'b0, cmd_appr} >= (AW + 1)'(N_APPR);

  // Out-of-range manual targets are swallowed without touching the mode.
  always_comb begin
    mode_d = mode_q;
    tgt_d  = tgt_q;
    if (accept && !bad_appr) begin
      mode_d = cmd_mode;
      if (cmd_mode == M_MANUAL) tgt_d = cmd_appr;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold    = 1'b0;
    if (state_q == ST_FLASH) begin
      if (mode_q != M_FLASH) state_d = ST_ALLRED;
    end else if (tick) begin
      unique case (state_q)
        ST_ALLRED: begin
          if (timer_q == TW'(ALLRED_T - 1)) begin
            unique case (1'b1)
              mode_q == M_FLASH:  state_d = ST_FLASH;
              mode_q == M_ALLRED: hold = 1'b1;
              mode_q == M_MANUAL: begin
                cur_d   = tgt_q;
                state_d = ST_GREEN;
              end
              default: state_d = ST_GREEN;
            endcase
          end
        end
        ST_GREEN: begin
          if (!(mode_q == M_MANUAL && tgt_q == cur_q) &&
              (mode_q != M_AUTO || timer_q == TW'(GREEN_T - 1)))
            state_d = ST_GFLASH;
        end
        ST_GFLASH: begin
          if (timer_q == TW'(GFLASH_T - 1)) state_d = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (timer_q == TW'(YELLOW_T - 1)) begin
            state_d = ST_ALLRED;
            if (mode_q == M_AUTO)
              cur_d = (cur_q == AW'(N_APPR - 1)) ? '0 : cur_q + 1'b1;
          end
        end
        default: state_d = ST_ALLRED;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q) timer_d = '0;
    else if (tick && !hold) timer_d = timer_q + 1'b1;
    else timer_d = timer_q;
  end

  // Lights follow the next-state values so they change with state_o.
  always_comb begin
    lights_d = {N_APPR{RED}};
    for (int i = 0; i < N_APPR; i++) begin
      unique case (state_d)
        ST_GREEN:
          if (AW'(i) == cur_d) lights_d[3*i +: 3] = GRN;
        ST_GFLASH:
          if (AW'(i) == cur_d) lights_d[3*i +: 3] = blink_d ? GRN : DARK;
        ST_YELLOW:
          if (AW'(i) == cur_d) lights_d[3*i +: 3] = YEL;
        ST_FLASH:
          lights_d[3*i +: 3] = blink_d ? YEL : DARK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q  <= '0;
      timer_q  <= '0;
      blink_q  <= 1'b0;
      state_q  <= ST_ALLRED;
      mode_q   <= M_AUTO;
      tgt_q    <= '0;
      cur_q    <= '0;
      lights_q <= {N_APPR{RED}};
    end else begin
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      blink_q  <= blink_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      lights_q <= lights_d;
    end
  end

  assign lights   = lights_q;
  assign cur_appr = cur_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: directed table, corner sequences,
// and random commands checked every cycle against a phase-level model.
module tb_traffic_phase_seq;

  localparam int NA   = 4;
  localparam int TDIV = 4;
  localparam int GT   = 3;
  localparam int GFT  = 2;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int TWB  = 8;

  localparam int P_AR = 0;
  localparam int P_GR = 1;
  localparam int P_GF = 2;
  localparam int P_YE = 3;
  localparam int P_FL = 4;

  localparam int MD_AUTO = 0;
  localparam int MD_MAN  = 1;
  localparam int MD_FL   = 2;
  localparam int MD_AR   = 3;

  localparam logic [11:0] ALLR = 12'b100_100_100_100;
  localparam logic [11:0] ALLY = 12'b010_010_010_010;
  localparam logic [11:0] ALLD = 12'b000_000_000_000;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_mode;
  logic [1:0]  cmd_appr;
  logic        cmd_ready;
  logic [11:0] lights;
  logic [1:0]  cur_appr;
  logic [2:0]  state_o;

  logic        b_valid;
  logic [1:0]  b_mode;
  logic [2:0]  b_appr;
  logic        b_ready;
  logic [14:0] b_lights;
  logic [2:0]  b_cur;
  logic [2:0]  b_state;

  traffic_phase_seq #(
    .N_APPR(NA), .TICK_DIV(TDIV), .GREEN_T(GT), .GFLASH_T(GFT),
    .YELLOW_T(YT), .ALLRED_T(ART), .TW(TWB)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_appr(cmd_appr), .cmd_ready(cmd_ready), .lights(lights),
    .cur_appr(cur_appr), .state_o(state_o)
  );

  traffic_phase_seq #(
    .N_APPR(5), .TICK_DIV(TDIV), .GREEN_T(GT), .GFLASH_T(GFT),
    .YELLOW_T(YT), .ALLRED_T(ART), .TW(TWB)
  ) dut5 (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_mode(b_mode),
    .cmd_appr(b_appr), .cmd_ready(b_ready), .lights(b_lights),
    .cur_appr(b_cur), .state_o(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;

  // Reference model: phase, ticks spent in phase, cycle within tick period.
  int m_cyc, m_ph, m_el, m_cur, m_tgt, m_mode;
  bit m_blink, m_tick;
  int dur[5] = '{ART, GT, GFT, YT, 1};

  task automatic model_edge(input bit rn, input bit v,
                            input int md, input int ap);
    bit tk, acc, adv, done;
    int nph;
    if (!rn) begin
      m_cyc = 0; m_ph = P_AR; m_el = 0; m_blink = 0;
      m_mode = MD_AUTO; m_tgt = 0; m_cur = 0; m_tick = 0;
      return;
    end
    tk   = (m_cyc == TDIV - 1);
    acc  = v && m_ph != P_GF && m_ph != P_YE;
    nph  = m_ph;
    adv  = tk;
    done = (m_el % (1 << TWB)) == dur[m_ph] - 1;
    if (m_ph == P_FL) begin
      if (m_mode != MD_FL) nph = P_AR;
    end else if (tk) begin
      case (m_ph)
        P_AR: if (done) begin
          if (m_mode == MD_FL) nph = P_FL;
          else if (m_mode == MD_AR) adv = 0;
          else begin
            if (m_mode == MD_MAN) m_cur = m_tgt;
            nph = P_GR;
          end
        end
        P_GR: if (!(m_mode == MD_MAN && m_tgt == m_cur) &&
                  (m_mode != MD_AUTO || done)) nph = P_GF;
        P_GF: if (done) nph = P_YE;
        default: if (done) begin
          nph = P_AR;
          if (m_mode == MD_AUTO) m_cur = (m_cur + 1) % NA;
        end
      endcase
    end
    if (nph != m_ph) m_el = 0;
    else if (adv) m_el++;
    m_ph    = nph;
    m_blink = m_blink ^ tk;
    m_cyc   = tk ? 0 : m_cyc + 1;
    m_tick  = tk;
    if (acc && !(md == MD_MAN && ap >= NA)) begin
      m_mode = md;
      if (md == MD_MAN) m_tgt = ap;
    end
  endtask

  always @(posedge clk)
    model_edge(rst, cmd_valid, int'(cmd_mode), int'(cmd_appr));

  function automatic logic [11:0] exp_lights(int ph, int cur, bit bl);
    logic [11:0] r;
    logic [2:0] f;
    for (int i = 0; i < NA; i++) begin
      case (ph)
        P_AR:    f = 3'b100;
        P_GR:    f = (i == cur) ? 3'b001 : 3'b100;
        P_GF:    f = (i == cur) ? (bl ? 3'b001 : 3'b000) : 3'b100;
        P_YE:    f = (i == cur) ? 3'b010 : 3'b100;
        default: f = bl ? 3'b010 : 3'b000;
      endcase
      r[3*i +: 3] = f;
    end
    return r;
  endfunction

  task automatic mon();
    logic [11:0] el;
    logic        er;
    if (!mon_en) return;
    el = exp_lights(m_ph, m_cur, m_blink);
    er = (m_ph != P_GF && m_ph != P_YE);
    n_vec++;
    if (lights !== el || state_o !== 3'(m_ph) ||
        cur_appr !== 2'(m_cur) || cmd_ready !== er) begin
      n_err++;
      $display("FAIL model @%0t: got st=%0d lights=%b cur=%0d rdy=%b, exp st=%0d lights=%b cur=%0d rdy=%b",
               $time, state_o, lights, cur_appr, cmd_ready,
               m_ph, el, m_cur, er);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  task automatic next_tick();
    for (int i = 0; i < 2 * TDIV; i++) begin
      cyc();
      if (m_tick) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL tick_wait: got no tick, exp one within %0d cycles", 2 * TDIV);
  endtask

  task automatic chk(input string nm, input logic [2:0] st,
                     input logic [11:0] li, input logic [1:0] cu,
                     input logic rdy);
    n_vec++;
    if (state_o !== st || lights !== li || cur_appr !== cu ||
        cmd_ready !== rdy) begin
      n_err++;
      $display("FAIL %s: got st=%0d lights=%b cur=%0d rdy=%b, exp st=%0d lights=%b cur=%0d rdy=%b",
               nm, state_o, lights, cur_appr, cmd_ready, st, li, cu, rdy);
    end
  endtask

  task automatic chk_b(input string nm, input logic [2:0] st,
                       input logic [14:0] li, input logic [2:0] cu);
    n_vec++;
    if (b_state !== st || b_lights !== li || b_cur !== cu) begin
      n_err++;
      $display("FAIL %s: got st=%0d lights=%b cur=%0d, exp st=%0d lights=%b cur=%0d",
               nm, b_state, b_lights, b_cur, st, li, cu);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [1:0]  md;
    logic [1:0]  ap;
    logic [7:0]  ticks;
    logic [2:0]  st;
    logic [11:0] li;
    logic [1:0]  cu;
    logic        rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Each row: drive inputs for one cycle, wait `ticks` ticks, compare.
    tbl[0]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd1, 12'b100_100_100_001, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd1, 12'b100_100_100_001, 2'd0, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd1, 12'b100_100_100_001, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd2, 12'b100_100_100_000, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd2, 12'b100_100_100_001, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd3, 12'b100_100_100_010, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd3, 12'b100_100_100_010, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd0, ALLR,                2'd1, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd1, 12'b100_100_001_100, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 2'd0, 8'd24, 3'd1, 12'b100_100_100_001, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 2'd2, 8'd6,  3'd1, 12'b100_001_100_100, 2'd2, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 2'd0, 8'd20, 3'd1, 12'b100_001_100_100, 2'd2, 1'b1};
    tbl[12] = '{1'b1, 2'd2, 2'd0, 8'd6,  3'd4, ALLY,                2'd2, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 2'd0, 8'd1,  3'd4, ALLD,                2'd2, 1'b1};

    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_appr = 2'd0;
    b_valid = 1'b0; b_mode = 2'd0; b_appr = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1;
    chk("reset", 3'd0, ALLR, 2'd0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].v;
      cmd_mode  = tbl[i].md;
      cmd_appr  = tbl[i].ap;
      cyc();
      cmd_valid = 1'b0;
      for (int t = 0; t < int'(tbl[i].ticks); t++) next_tick();
      chk($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].li, tbl[i].cu,
          tbl[i].rdy);
    end

    // FLASH left on the first cycle after AUTO lands, without a tick.
    cmd_valid = 1'b1; cmd_mode = 2'd0;
    cyc();
    cmd_valid = 1'b0;
    chk("flash_hold", 3'd4, ALLD, 2'd2, 1'b1);
    cyc();
    chk("flash_exit", 3'd0, ALLR, 2'd2, 1'b1);
    next_tick();
    chk("flash_green", 3'd1, 12'b100_001_100_100, 2'd2, 1'b1);

    // Command held through GFLASH/YELLOW is only taken in ALLRED.
    repeat (3) next_tick();
    chk("gflash_rdy", 3'd2, 12'b100_000_100_100, 2'd2, 1'b0);
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_appr = 2'd0;
    next_tick();
    chk("gflash_busy", 3'd2, 12'b100_001_100_100, 2'd2, 1'b0);
    next_tick();
    chk("yellow_busy", 3'd3, 12'b100_010_100_100, 2'd2, 1'b0);
    repeat (2) next_tick();
    chk("allred_rdy", 3'd0, ALLR, 2'd3, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    next_tick();
    chk("allred_hold1", 3'd0, ALLR, 2'd3, 1'b1);
    repeat (3) next_tick();
    chk("allred_hold4", 3'd0, ALLR, 2'd3, 1'b1);

    // Reset in the middle of GFLASH.
    cmd_valid = 1'b1; cmd_mode = 2'd0;
    cyc();
    cmd_valid = 1'b0;
    next_tick();
    chk("auto_resume", 3'd1, 12'b001_100_100_100, 2'd3, 1'b1);
    repeat (3) next_tick();
    chk("pre_reset", 3'd2, 12'b000_100_100_100, 2'd3, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mid_reset", 3'd0, ALLR, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("presc_wait%0d", i), 3'd0, ALLR, 2'd0, 1'b1);
    end
    cyc();
    chk("presc_tick", 3'd1, 12'b100_100_100_001, 2'd0, 1'b1);

    // Out-of-range manual target on a 5-approach instance is ignored.
    b_valid = 1'b1; b_mode = 2'd1; b_appr = 3'd5;
    cyc();
    b_valid = 1'b0;
    next_tick();
    chk_b("bad_appr_green", 3'd1, 15'b100_100_100_100_001, 3'd0);
    repeat (7) next_tick();
    chk_b("bad_appr_auto", 3'd1, 15'b100_100_100_001_100, 3'd1);

    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 15) == 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_appr  = 2'($urandom_range(0, 3));
      rst       = ($urandom_range(0, 599) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
